// File: rtl/microwave_timer_ctrl_if.sv
// Signal bundle between the keypad/door front-end, the countdown sequencer
// and the 7-segment display path.
interface microwave_timer_ctrl_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       mag_on;
  logic       done;
  logic [1:0] state;

  // Front-end side: drives requests, observes time and status.
  modport master (
    output key_valid, key_digit, start, stop, door_closed,
    input  sec_ones, sec_tens, min_ones, mag_on, done, state
  );

  // Sequencer side.
  modport slave (
    input  key_valid, key_digit, start, stop, door_closed,
    output sec_ones, sec_tens, min_ones, mag_on, done, state
  );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// Microwave m:ss countdown sequencer: BCD keypad entry, mod-10/6/10 borrow
// cascade at one step per prescaled second, and start/pause/stop sequencing
// of the magnetron enable and done flag. All outputs are registered.
module microwave_timer_ctrl #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic                  clk,
  input  logic                  clear,
  microwave_timer_ctrl_if.slave bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_sec_ones, r_sec_tens, r_min_ones;
  logic [3:0]    w_sec_ones_nxt, w_sec_tens_nxt, w_min_ones_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_mag_on, r_done, w_mag_on_nxt, w_done_nxt;

  logic w_t_zero;
  logic w_last_sec;
  logic w_key_ok;
  logic w_run_hold;
  logic w_wrap;

  assign w_t_zero   = (r_sec_ones == 4'd0) && (r_sec_tens == 4'd0) && (r_min_ones == 4'd0);
  // The next tick would land on 0:00.
  assign w_last_sec = (r_sec_ones == 4'd1) && (r_sec_tens == 4'd0) && (r_min_ones == 4'd0);
  // A key is accepted only if the outgoing sec_ones is a legal tens digit.
  assign w_key_ok   = bus.key_valid && (bus.key_digit <= 4'd9) && (r_sec_ones <= 4'd5);
  assign w_run_hold = bus.stop || !bus.door_closed;
  assign w_wrap     = (r_presc == PRESC_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; stop outranks door, door outranks start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.stop && bus.start && bus.door_closed && !w_t_zero) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_run_hold)               w_state_nxt = S_PAUSE;
        else if (w_wrap && w_last_sec) w_state_nxt = S_DONE;
      end
      S_PAUSE: begin
        if (bus.stop)                            w_state_nxt = S_IDLE;
        else if (bus.start && bus.door_closed)   w_state_nxt = S_RUN;
      end
      S_DONE: begin
        if (bus.start || bus.stop || bus.key_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Digit and prescaler next values: key shift, borrow cascade, clears.
  always_comb begin
    w_sec_ones_nxt = r_sec_ones;
    w_sec_tens_nxt = r_sec_tens;
    w_min_ones_nxt = r_min_ones;
    w_presc_nxt    = r_presc;
    case (r_state)
      S_IDLE: begin
        if (bus.stop) begin
          w_sec_ones_nxt = 4'd0;
          w_sec_tens_nxt = 4'd0;
          w_min_ones_nxt = 4'd0;
        end else if (bus.start) begin
          // Start claims the cycle; a coincident key is dropped.
          if (w_state_nxt == S_RUN) w_presc_nxt = '0;
        end else if (w_key_ok) begin
          w_min_ones_nxt = r_sec_tens;
          w_sec_tens_nxt = r_sec_ones;
          w_sec_ones_nxt = bus.key_digit;
        end
      end
      S_RUN: begin
        // A pause freezes the prescaler, so an in-flight tick is deferred.
        if (!w_run_hold) begin
          if (w_wrap) begin
            w_presc_nxt = '0;
            if (r_sec_ones != 4'd0) begin
              w_sec_ones_nxt = r_sec_ones - 4'd1;
            end else begin
              w_sec_ones_nxt = 4'd9;
              if (r_sec_tens != 4'd0) begin
                w_sec_tens_nxt = r_sec_tens - 4'd1;
              end else begin
                w_sec_tens_nxt = 4'd5;
                w_min_ones_nxt = r_min_ones - 4'd1;
              end
            end
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          w_sec_ones_nxt = 4'd0;
          w_sec_tens_nxt = 4'd0;
          w_min_ones_nxt = 4'd0;
          w_presc_nxt    = '0;
        end
      end
      default: ;
    endcase
  end

  // Output decode from the next state so status flags align with the state.
  always_comb begin
    w_mag_on_nxt = (w_state_nxt == S_RUN);
    w_done_nxt   = (w_state_nxt == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_presc    <= '0;
      r_mag_on   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_sec_ones <= w_sec_ones_nxt;
      r_sec_tens <= w_sec_tens_nxt;
      r_min_ones <= w_min_ones_nxt;
      r_presc    <= w_presc_nxt;
      r_mag_on   <= w_mag_on_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.sec_ones = r_sec_ones;
  assign bus.sec_tens = r_sec_tens;
  assign bus.min_ones = r_min_ones;
  assign bus.mag_on   = r_mag_on;
  assign bus.done     = r_done;
  assign bus.state    = r_state;

endmodule
